axi4_lite_cmd_master: RTL and testbench
=======================================

AXI4_LITE_CMD_MASTER -- requirements
Module: axi4_lite_cmd_master

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 32, AXI4-Lite address width.
- TIMEOUT, 1024, cycles allowed per outstanding channel phase before abort (>=2).
REQ-002 Ports SHALL be, one per line:
- clk_i  input  1  single clock; all logic on rising edge.
- rst_i  input  1  reset, asynchronous assert, active-low.
- cmd_valid_i  input  1  command valid.
- cmd_ready_o  output  1  command accepted when valid&&ready.
- cmd_wr_i  input  1  1=write, 0=read.
- cmd_addr_i  input  ADDR_W  byte address.
- cmd_wdata_i  input  32  write data.
- cmd_wstrb_i  input  4  write byte strobes.
- rsp_valid_o  output  1  response valid, one-cycle pulse.
- rsp_rdata_o  output  32  read data; 0 for writes.
- rsp_resp_o  output  2  BRESP/RRESP, or 2'b11 on timeout.
- rsp_timeout_o  output  1  set with rsp_valid_o when the phase timed out.
- csr_o  axi4_lite_if.master  --  AXI4-Lite master port.
REQ-003 Clock and reset SHALL be one clock; reset is asynchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-005 cmd_ready_o SHALL be 1 only in IDLE; command fields are latched on acceptance.
REQ-006 IDLE->WR_REQ on accepted write; IDLE->RD_REQ on accepted read.
REQ-007 In WR_REQ, awvalid and wvalid SHALL both be registered high the cycle after acceptance; awaddr/wdata/wstrb held stable.
REQ-008 awvalid SHALL drop the cycle after its own handshake; wvalid likewise, independently; AW and W handshakes may occur in either order or the same cycle.
REQ-009 WR_REQ->WR_RESP when both AW and W handshakes are complete; bready SHALL be 1 only in WR_RESP.
REQ-010 WR_RESP->DONE on bvalid&&bready; bresp is captured.
REQ-011 In RD_REQ, arvalid SHALL be high with araddr held; it drops after the handshake; RD_REQ->RD_RESP.
REQ-012 rready SHALL be 1 only in RD_RESP; RD_RESP->DONE on rvalid&&rready; rdata and rresp are captured.
REQ-013 In DONE, rsp_valid_o=1 for exactly one cycle with the captured data; DONE->IDLE; there is no response backpressure.
REQ-014 awprot/arprot SHALL be 3'b000; only one transaction is outstanding at any time.
REQ-015 A phase counter SHALL clear on every state entry and increment in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
REQ-016 When the counter reaches TIMEOUT-1, all AXI valid/ready outputs SHALL drop and the FSM goes to DONE with rsp_resp_o=2'b11, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-017 A handshake in the same cycle as the timeout SHALL win; no timeout is reported.
REQ-018 Nominal latency against a zero-wait slave (AW/W/AR ready high, response 2 cycles after address): command accepted at cycle N, rsp_valid_o at N+4 for both reads and writes.
REQ-019 rsp_rdata_o/rsp_resp_o SHALL hold the last response until the next DONE.

Reset
REQ-020 While rst_i=0: state IDLE; awvalid, wvalid, arvalid, bready, rready, rsp_valid_o, rsp_timeout_o = 0; rsp_rdata_o=0; rsp_resp_o=0; counter=0; cmd_ready_o=1 after release.
REQ-021 Reset mid-transaction SHALL abort without a response; the first post-reset command is serviced normally.

Verification
REQ-022 Write 0x0000_000C, data 0xDEAD_BEEF, strb 4'hF, zero-wait slave -> one AW and one W handshake, bready seen, rsp_valid_o at N+4 with resp=0, rdata=0.
REQ-023 Read 0x0000_0014, slave returns 0x1234_5678 -> one AR handshake, rsp_valid_o at N+4 with rdata=0x1234_5678, resp=0.
REQ-024 Write with slave awready delayed 3 cycles after wready -> wvalid drops after its handshake, awvalid is held; single bvalid accepted; response OK.
REQ-025 TIMEOUT=16, slave never asserts arready -> arvalid drops at 16 cycles, rsp_valid_o with resp=2'b11, timeout=1; next command serviced normally.
REQ-026 rst_i low while in WR_RESP -> all AXI valids/readies 0, no rsp_valid_o; following read completes correctly.
REQ-027 cmd_valid_i held high continuously with back-to-back commands -> each command accepted only in IDLE, responses in order with one rsp_valid_o per command.

Source files
------------

// File: rtl/axi4_lite_cmd_master_if.sv
// AXI4-Lite bus bundle shared by the command master and its slave.
// The master modport drives requests; the slave modport answers them.
interface axi4_lite_if #(
  parameter int ADDR_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI
// read or write and returns a one-cycle response, aborting stalled phases.
module axi4_lite_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_wr_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [31:0]       cmd_wdata_i,
  input  logic [3:0]        cmd_wstrb_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic [1:0]        rsp_resp_o,
  output logic              rsp_timeout_o,
  axi4_lite_if.master       csr_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        wstrb_r;
  logic              awvalid_r, wvalid_r, arvalid_r, bready_r, rready_r;
  logic              awvalid_nxt_s, wvalid_nxt_s, arvalid_nxt_s, bready_nxt_s, rready_nxt_s;
  logic              aw_done_r, w_done_r, aw_done_nxt_s, w_done_nxt_s;
  logic              cmd_ready_r;
  logic              rsp_valid_r, rsp_timeout_r;
  logic [31:0]       rsp_rdata_r;
  logic [1:0]        rsp_resp_r;
  logic              latch_cmd_s;
  logic              cap_en_s, cap_to_s;
  logic [31:0]       cap_rdata_s;
  logic [1:0]        cap_resp_s;
  logic              aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic              aw_all_s, w_all_s, timeout_s;

  assign aw_hs_s   = awvalid_r & csr_o.awready;
  assign w_hs_s    = wvalid_r & csr_o.wready;
  assign b_hs_s    = bready_r & csr_o.bvalid;
  assign ar_hs_s   = arvalid_r & csr_o.arready;
  assign r_hs_s    = rready_r & csr_o.rvalid;
  assign aw_all_s  = aw_done_r | aw_hs_s;
  assign w_all_s   = w_done_r | w_hs_s;
  assign timeout_s = (cnt_r == CNT_LAST);

  // Next state, next AXI handshake outputs and response capture.
  always_comb begin
    state_nxt_s   = state_r;
    awvalid_nxt_s = 1'b0;
    wvalid_nxt_s  = 1'b0;
    arvalid_nxt_s = 1'b0;
    bready_nxt_s  = 1'b0;
    rready_nxt_s  = 1'b0;
    aw_done_nxt_s = aw_done_r;
    w_done_nxt_s  = w_done_r;
    latch_cmd_s   = 1'b0;
    cap_en_s      = 1'b0;
    cap_to_s      = 1'b0;
    cap_rdata_s   = 32'h0000_0000;
    cap_resp_s    = 2'b00;
    case (state_r)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_r) begin
          latch_cmd_s   = 1'b1;
          aw_done_nxt_s = 1'b0;
          w_done_nxt_s  = 1'b0;
          if (cmd_wr_i) begin
            state_nxt_s   = WR_REQ;
            awvalid_nxt_s = 1'b1;
            wvalid_nxt_s  = 1'b1;
          end else begin
            state_nxt_s   = RD_REQ;
            arvalid_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR_REQ: begin
        // A completing handshake beats a simultaneous timeout.
        if (aw_all_s && w_all_s) begin
          state_nxt_s  = WR_RESP;
          bready_nxt_s = 1'b1;
        end else if (timeout_s) begin
          state_nxt_s = DONE;
          cap_en_s    = 1'b1;
          cap_to_s    = 1'b1;
          cap_resp_s  = 2'b11;
        end else begin
          awvalid_nxt_s = awvalid_r & ~aw_hs_s;
          wvalid_nxt_s  = wvalid_r & ~w_hs_s;
          aw_done_nxt_s = aw_all_s;
          w_done_nxt_s  = w_all_s;
        end
      end
      WR_RESP: begin
        if (b_hs_s) begin
          state_nxt_s = DONE;
          cap_en_s    = 1'b1;
          cap_resp_s  = csr_o.bresp;
        end else if (timeout_s) begin
          state_nxt_s = DONE;
          cap_en_s    = 1'b1;
          cap_to_s    = 1'b1;
          cap_resp_s  = 2'b11;
        end else begin
          bready_nxt_s = 1'b1;
        end
      end
      RD_REQ: begin
        if (ar_hs_s) begin
          state_nxt_s  = RD_RESP;
          rready_nxt_s = 1'b1;
        end else if (timeout_s) begin
          state_nxt_s = DONE;
          cap_en_s    = 1'b1;
          cap_to_s    = 1'b1;
          cap_resp_s  = 2'b11;
        end else begin
          arvalid_nxt_s = 1'b1;
        end
      end
      RD_RESP: begin
        if (r_hs_s) begin
          state_nxt_s = DONE;
          cap_en_s    = 1'b1;
          cap_rdata_s = csr_o.rdata;
          cap_resp_s  = csr_o.rresp;
        end else if (timeout_s) begin
          state_nxt_s = DONE;
          cap_en_s    = 1'b1;
          cap_to_s    = 1'b1;
          cap_resp_s  = 2'b11;
        end else begin
          rready_nxt_s = 1'b1;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Phase counter: restarts on every state change, runs only in bus phases.
  always_comb begin
    if (state_nxt_s != state_r) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (state_r inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) begin
      cnt_nxt_s = cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end
  end

  // State, counter and registered AXI handshake outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      bready_r    <= 1'b0;
      rready_r    <= 1'b0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      awvalid_r   <= awvalid_nxt_s;
      wvalid_r    <= wvalid_nxt_s;
      arvalid_r   <= arvalid_nxt_s;
      bready_r    <= bready_nxt_s;
      rready_r    <= rready_nxt_s;
      aw_done_r   <= aw_done_nxt_s;
      w_done_r    <= w_done_nxt_s;
      cmd_ready_r <= (state_nxt_s == IDLE);
    end
  end

  // Command fields held stable for the whole transaction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= 32'h0000_0000;
      wstrb_r <= 4'h0;
    end else if (latch_cmd_s) begin
      addr_r  <= cmd_addr_i;
      wdata_r <= cmd_wdata_i;
      wstrb_r <= cmd_wstrb_i;
    end else begin
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      wstrb_r <= wstrb_r;
    end
  end

  // Response pulse; data and code persist until the next completion.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rsp_valid_r   <= 1'b0;
      rsp_timeout_r <= 1'b0;
      rsp_rdata_r   <= 32'h0000_0000;
      rsp_resp_r    <= 2'b00;
    end else begin
      rsp_valid_r   <= (state_nxt_s == DONE);
      rsp_timeout_r <= (state_nxt_s == DONE) & cap_to_s;
      if (cap_en_s) begin
        rsp_rdata_r <= cap_rdata_s;
        rsp_resp_r  <= cap_resp_s;
      end else begin
        rsp_rdata_r <= rsp_rdata_r;
        rsp_resp_r  <= rsp_resp_r;
      end
    end
  end

  assign cmd_ready_o   = cmd_ready_r;
  assign rsp_valid_o   = rsp_valid_r;
  assign rsp_rdata_o   = rsp_rdata_r;
  assign rsp_resp_o    = rsp_resp_r;
  assign rsp_timeout_o = rsp_timeout_r;

  assign csr_o.awvalid = awvalid_r;
  assign csr_o.awaddr  = addr_r;
  assign csr_o.awprot  = 3'b000;
  assign csr_o.wvalid  = wvalid_r;
  assign csr_o.wdata   = wdata_r;
  assign csr_o.wstrb   = wstrb_r;
  assign csr_o.bready  = bready_r;
  assign csr_o.arvalid = arvalid_r;
  assign csr_o.araddr  = addr_r;
  assign csr_o.arprot  = 3'b000;
  assign csr_o.rready  = rready_r;

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Bench for axi4_lite_cmd_master: memory-backed slave with configurable
// stalls, a command-level reference model and bus protocol monitor.
module tb_axi4_lite_cmd_master;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk_i       = 1'b0;
  logic              rst_i       = 1'b0;
  logic              cmd_valid_i = 1'b0;
  logic              cmd_wr_i    = 1'b0;
  logic [ADDR_W-1:0] cmd_addr_i  = 32'h0;
  logic [31:0]       cmd_wdata_i = 32'h0;
  logic [3:0]        cmd_wstrb_i = 4'h0;
  logic              cmd_ready_o, rsp_valid_o, rsp_timeout_o;
  logic [31:0]       rsp_rdata_o;
  logic [1:0]        rsp_resp_o;

  axi4_lite_if #(.ADDR_W(ADDR_W)) csr ();

  axi4_lite_cmd_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
    .rsp_timeout_o(rsp_timeout_o), .csr_o(csr)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // slave behaviour knobs
  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_extra = 0;
  bit ar_block = 1'b0;
  logic [31:0] slv_mem [16];
  logic [31:0] mdl_mem [16];
  int aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0, b_hs_cnt = 0, r_hs_cnt = 0;

  // monitor results
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
    bit          chk_lat;
    int          acc_cyc;
  } exp_t;
  exp_t exp_q[$];
  int rsp_cnt = 0, acc_cnt = 0, ar_high = 0;
  bit aw_only_seen = 1'b0;

  function automatic logic [1:0] slave_resp(input logic [3:0] idx);
    return (idx >= 4'd14) ? 2'b10 : 2'b00;
  endfunction

  // Memory-backed AXI4-Lite slave, stepping 1 time unit after each edge.
  initial begin : slave
    logic p_awv, p_wv, p_arv, p_br, p_rr;
    logic [3:0] p_awidx, p_aridx, aw_idx, r_idx;
    logic [31:0] p_wdata, wd, mask;
    logic [3:0] p_wstrb, ws;
    logic [1:0] b_code;
    int aw_seen, w_seen, ar_seen, b_cd, r_cd;
    bit aw_got, w_got;
    p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0; p_br = 1'b0; p_rr = 1'b0;
    aw_seen = 0; w_seen = 0; ar_seen = 0; b_cd = 0; r_cd = 0;
    aw_got = 1'b0; w_got = 1'b0; aw_idx = 4'h0; r_idx = 4'h0; b_code = 2'b00;
    wd = 32'h0; ws = 4'h0; p_awidx = 4'h0; p_aridx = 4'h0; p_wdata = 32'h0; p_wstrb = 4'h0;
    csr.awready = 1'b0; csr.wready = 1'b0; csr.arready = 1'b0;
    csr.bvalid = 1'b0; csr.bresp = 2'b00; csr.rvalid = 1'b0;
    csr.rdata = 32'h0; csr.rresp = 2'b00;
    forever begin
      @(posedge clk_i); #1;
      if (!rst_i) begin
        p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0; p_br = 1'b0; p_rr = 1'b0;
        aw_seen = 0; w_seen = 0; ar_seen = 0; b_cd = 0; r_cd = 0;
        aw_got = 1'b0; w_got = 1'b0;
        csr.awready = 1'b0; csr.wready = 1'b0; csr.arready = 1'b0;
        csr.bvalid = 1'b0; csr.rvalid = 1'b0;
      end else begin
        if (p_awv && csr.awready) begin aw_hs_cnt++; aw_got = 1'b1; aw_idx = p_awidx; end
        if (p_wv && csr.wready) begin w_hs_cnt++; w_got = 1'b1; wd = p_wdata; ws = p_wstrb; end
        if (aw_got && w_got) begin
          mask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
          slv_mem[aw_idx] = (slv_mem[aw_idx] & ~mask) | (wd & mask);
          b_code = slave_resp(aw_idx);
          aw_got = 1'b0; w_got = 1'b0;
          b_cd = 2 + b_extra;
        end
        if (p_arv && csr.arready) begin ar_hs_cnt++; r_idx = p_aridx; r_cd = 2; end
        if (p_br && csr.bvalid) begin b_hs_cnt++; csr.bvalid = 1'b0; end
        if (p_rr && csr.rvalid) begin r_hs_cnt++; csr.rvalid = 1'b0; end
        if (b_cd > 0) begin
          b_cd--;
          if (b_cd == 0) begin csr.bvalid = 1'b1; csr.bresp = b_code; end
        end
        if (r_cd > 0) begin
          r_cd--;
          if (r_cd == 0) begin
            csr.rvalid = 1'b1; csr.rdata = slv_mem[r_idx]; csr.rresp = slave_resp(r_idx);
          end
        end
        p_awv = csr.awvalid; p_wv = csr.wvalid; p_arv = csr.arvalid;
        p_br = csr.bready; p_rr = csr.rready;
        p_awidx = csr.awaddr[5:2]; p_aridx = csr.araddr[5:2];
        p_wdata = csr.wdata; p_wstrb = csr.wstrb;
        csr.awready = p_awv && (aw_seen >= aw_wait);
        aw_seen = (p_awv && !csr.awready) ? aw_seen + 1 : 0;
        csr.wready = p_wv && (w_seen >= w_wait);
        w_seen = (p_wv && !csr.wready) ? w_seen + 1 : 0;
        csr.arready = p_arv && !ar_block && (ar_seen >= ar_wait);
        ar_seen = (p_arv && !csr.arready) ? ar_seen + 1 : 0;
      end
    end
  end

  // Reference model and protocol monitor, sampling 2 time units after each edge.
  initial begin : monitor
    exp_t e;
    logic [3:0] idx;
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_araddr, p_wdata;
    logic aw, w, ar, br, rr;
    p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0; p_arv = 1'b0; p_arr = 1'b0;
    p_awaddr = 32'h0; p_araddr = 32'h0; p_wdata = 32'h0;
    forever begin
      @(posedge clk_i); #2;
      cyc++;
      if (!rst_i) begin
        exp_q.delete();
        p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0;
      end else begin
        if (cmd_valid_i && cmd_ready_o) begin
          idx = cmd_addr_i[5:2];
          e.acc_cyc = cyc;
          e.chk_lat = (aw_wait == 0) && (w_wait == 0) && (ar_wait == 0) && (b_extra == 0) && !ar_block;
          e.to = 1'b0;
          if (cmd_wr_i) begin
            for (int b = 0; b < 4; b++)
              if (cmd_wstrb_i[b]) mdl_mem[idx][8*b +: 8] = cmd_wdata_i[8*b +: 8];
            e.rdata = 32'h0; e.resp = slave_resp(idx);
          end else if (ar_block) begin
            e.rdata = 32'h0; e.resp = 2'b11; e.to = 1'b1;
          end else begin
            e.rdata = mdl_mem[idx]; e.resp = slave_resp(idx);
          end
          exp_q.push_back(e);
          acc_cnt++;
          ar_high = 0;
        end
        aw = csr.awvalid; w = csr.wvalid; ar = csr.arvalid; br = csr.bready; rr = csr.rready;
        if (ar) ar_high++;
        if (aw && !w) aw_only_seen = 1'b1;
        if (rsp_valid_o) begin
          rsp_cnt++;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rsp_unexpected: got rsp_valid_o with rdata=%h resp=%b, no command pending", rsp_rdata_o, rsp_resp_o);
          end else begin
            e = exp_q.pop_front();
            if (rsp_rdata_o !== e.rdata || rsp_resp_o !== e.resp || rsp_timeout_o !== e.to || cmd_ready_o !== 1'b0) begin
              fails++;
              $display("FAIL rsp_data: got rdata=%h resp=%b to=%b rdy=%b, expected rdata=%h resp=%b to=%b rdy=0",
                       rsp_rdata_o, rsp_resp_o, rsp_timeout_o, cmd_ready_o, e.rdata, e.resp, e.to);
            end
            if (e.chk_lat) begin
              tests++;
              if (cyc - e.acc_cyc != 4) begin
                fails++;
                $display("FAIL rsp_latency: got %0d cycles, expected 4", cyc - e.acc_cyc);
              end
            end
          end
        end
        if (aw || w || ar || br || rr) begin
          tests++;
          if (cmd_ready_o !== 1'b0 || ((aw || w) && (ar || br || rr)) || (ar && (br || rr)) || (br && rr) ||
              csr.awprot !== 3'b000 || csr.arprot !== 3'b000) begin
            fails++;
            $display("FAIL bus_exclusive: got aw=%b w=%b ar=%b b=%b r=%b rdy=%b prot=%b/%b, expected one phase, rdy=0, prot=0",
                     aw, w, ar, br, rr, cmd_ready_o, csr.awprot, csr.arprot);
          end
        end
        if (p_awv) begin
          tests++;
          if (p_awr ? (aw !== 1'b0) : (aw !== 1'b1 || csr.awaddr !== p_awaddr)) begin
            fails++;
            $display("FAIL aw_stable: got awvalid=%b addr=%h after hs=%b, expected %b addr=%h", aw, csr.awaddr, p_awr, !p_awr, p_awaddr);
          end
        end
        if (p_wv) begin
          tests++;
          if (p_wr ? (w !== 1'b0) : (w !== 1'b1 || csr.wdata !== p_wdata)) begin
            fails++;
            $display("FAIL w_stable: got wvalid=%b data=%h after hs=%b, expected %b data=%h", w, csr.wdata, p_wr, !p_wr, p_wdata);
          end
        end
        if (p_arv && !ar_block) begin
          tests++;
          if (p_arr ? (ar !== 1'b0) : (ar !== 1'b1 || csr.araddr !== p_araddr)) begin
            fails++;
            $display("FAIL ar_stable: got arvalid=%b addr=%h after hs=%b, expected %b addr=%h", ar, csr.araddr, p_arr, !p_arr, p_araddr);
          end
        end
        p_awv = aw; p_awr = csr.awready; p_awaddr = csr.awaddr;
        p_wv = w; p_wr = csr.wready; p_wdata = csr.wdata;
        p_arv = ar; p_arr = csr.arready; p_araddr = csr.araddr;
      end
    end
  end

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    n = 0;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b1; cmd_wr_i = wr; cmd_addr_i = addr; cmd_wdata_i = data; cmd_wstrb_i = strb;
    while (!cmd_ready_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    tests++;
    if (n >= 100) begin
      fails++;
      $display("FAIL cmd_accept: got no cmd_ready_o in 100 cycles, expected acceptance");
    end
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n;
    n = 0;
    while (rsp_cnt < target && n < budget) begin
      @(posedge clk_i); #3;
      n++;
    end
    tests++;
    if (rsp_cnt < target) begin
      fails++;
      $display("FAIL rsp_wait: got %0d responses, expected %0d within %0d cycles", rsp_cnt, target, budget);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #2;
    tests++;
    if ({csr.awvalid, csr.wvalid, csr.arvalid, csr.bready, csr.rready} !== 5'b00000) begin
      fails++;
      $display("FAIL reset_axi: got %b, expected 00000", {csr.awvalid, csr.wvalid, csr.arvalid, csr.bready, csr.rready});
    end
    tests++;
    if (rsp_valid_o !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b, expected 0", rsp_valid_o); end
    tests++;
    if (rsp_rdata_o !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h, expected 0", rsp_rdata_o); end
    tests++;
    if (rsp_resp_o !== 2'b00) begin fails++; $display("FAIL reset_resp: got %b, expected 00", rsp_resp_o); end
    tests++;
    if (rsp_timeout_o !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b, expected 0", rsp_timeout_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #2;
    tests++;
    if (cmd_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b, expected 1", cmd_ready_o); end
  endtask

  task automatic test_write_basic();
    int base, aw0, w0, b0;
    base = rsp_cnt; aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
    issue(1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(base + 1, 30);
    repeat (3) @(posedge clk_i);
    #3;
    tests++;
    if (aw_hs_cnt - aw0 != 1 || w_hs_cnt - w0 != 1 || b_hs_cnt - b0 != 1 || rsp_cnt != base + 1) begin
      fails++;
      $display("FAIL write_counts: got aw=%0d w=%0d b=%0d rsp=%0d, expected 1 1 1 1",
               aw_hs_cnt - aw0, w_hs_cnt - w0, b_hs_cnt - b0, rsp_cnt - base);
    end
  endtask

  task automatic test_read_basic();
    int base, ar0;
    slv_mem[5] = 32'h1234_5678;
    mdl_mem[5] = 32'h1234_5678;
    base = rsp_cnt; ar0 = ar_hs_cnt;
    issue(1'b0, 32'h0000_0014, 32'h0, 4'h0);
    wait_rsp(base + 1, 30);
    tests++;
    if (ar_hs_cnt - ar0 != 1) begin fails++; $display("FAIL read_ar_count: got %0d, expected 1", ar_hs_cnt - ar0); end
    tests++;
    if (rsp_rdata_o !== 32'h1234_5678) begin fails++; $display("FAIL read_hold: got %h, expected 12345678", rsp_rdata_o); end
    issue(1'b0, 32'h0000_000C, 32'h0, 4'h0);
    wait_rsp(base + 2, 30);
  endtask

  task automatic test_aw_delay();
    int base, aw0, w0, b0;
    base = rsp_cnt; aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
    aw_wait = 3; aw_only_seen = 1'b0;
    issue(1'b1, 32'h0000_0020, $urandom, 4'hF);
    wait_rsp(base + 1, 40);
    aw_wait = 0;
    tests++;
    if (aw_only_seen !== 1'b1) begin fails++; $display("FAIL aw_delay_hold: got awvalid-only=%b, expected 1", aw_only_seen); end
    tests++;
    if (aw_hs_cnt - aw0 != 1 || w_hs_cnt - w0 != 1 || b_hs_cnt - b0 != 1) begin
      fails++;
      $display("FAIL aw_delay_counts: got aw=%0d w=%0d b=%0d, expected 1 1 1", aw_hs_cnt - aw0, w_hs_cnt - w0, b_hs_cnt - b0);
    end
  endtask

  task automatic test_timeout();
    int base, ar0;
    base = rsp_cnt; ar0 = ar_hs_cnt;
    ar_block = 1'b1;
    issue(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    wait_rsp(base + 1, 60);
    ar_block = 1'b0;
    tests++;
    if (ar_high != TIMEOUT) begin fails++; $display("FAIL timeout_arvalid: got %0d cycles, expected %0d", ar_high, TIMEOUT); end
    tests++;
    if (ar_hs_cnt != ar0) begin fails++; $display("FAIL timeout_ar_hs: got %0d, expected 0", ar_hs_cnt - ar0); end
    issue(1'b0, 32'h0000_0014, 32'h0, 4'h0);
    wait_rsp(base + 2, 30);
  endtask

  task automatic test_reset_mid();
    int base, n;
    b_extra = 6;
    issue(1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4'b0101);
    n = 0;
    while (csr.bready !== 1'b1 && n < 30) begin @(posedge clk_i); #1; n++; end
    tests++;
    if (csr.bready !== 1'b1) begin fails++; $display("FAIL mid_bready: got %b, expected 1", csr.bready); end
    base = rsp_cnt;
    rst_i = 1'b0;
    #1;
    tests++;
    if ({csr.awvalid, csr.wvalid, csr.arvalid, csr.bready, csr.rready, rsp_valid_o} !== 6'b000000) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %b, expected 000000", {csr.awvalid, csr.wvalid, csr.arvalid, csr.bready, csr.rready, rsp_valid_o});
    end
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    b_extra = 0;
    repeat (10) @(posedge clk_i);
    #3;
    tests++;
    if (rsp_cnt != base) begin fails++; $display("FAIL mid_no_rsp: got %0d responses, expected 0", rsp_cnt - base); end
    issue(1'b0, 32'h0000_0014, 32'h0, 4'h0);
    wait_rsp(base + 1, 30);
  endtask

  task automatic test_back_to_back(input int n, input bit rand_waits);
    int base, acc0, sent, budget;
    bit rdy_prev;
    base = rsp_cnt; acc0 = acc_cnt; sent = 0; budget = 0;
    if (rand_waits) begin
      aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3); ar_wait = $urandom_range(0, 3);
    end
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b1; cmd_wr_i = 1'($urandom_range(0, 1));
    cmd_addr_i = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
    cmd_wdata_i = $urandom; cmd_wstrb_i = 4'($urandom_range(0, 15));
    rdy_prev = cmd_ready_o;
    while (sent < n && budget < 40 * n) begin
      @(posedge clk_i); #1;
      budget++;
      if (rdy_prev) begin
        sent++;
        if (sent < n) begin
          cmd_wr_i = 1'($urandom_range(0, 1));
          cmd_addr_i = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
          cmd_wdata_i = $urandom; cmd_wstrb_i = 4'($urandom_range(0, 15));
        end else begin
          cmd_valid_i = 1'b0;
        end
      end
      rdy_prev = cmd_ready_o;
    end
    cmd_valid_i = 1'b0;
    wait_rsp(base + n, 40);
    aw_wait = 0; w_wait = 0; ar_wait = 0;
    tests++;
    if (acc_cnt - acc0 != n || exp_q.size() != 0 || rsp_cnt - base != n) begin
      fails++;
      $display("FAIL b2b_counts: got accepted=%0d responses=%0d pending=%0d, expected %0d %0d 0",
               acc_cnt - acc0, rsp_cnt - base, exp_q.size(), n, n);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      slv_mem[i] = v;
      mdl_mem[i] = v;
    end
    test_reset();
    test_write_basic();
    test_read_basic();
    test_aw_delay();
    test_timeout();
    test_reset_mid();
    test_back_to_back(24, 1'b0);
    test_back_to_back(24, 1'b1);
    repeat (5) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
